// File: rtl/glb_stream_pkg.sv
// ----------------------------------------------------------------------------
// glb_stream_pkg
//
// Shared definitions for the 17-bit global-buffer stream used by the sparse
// memory-core test environment.
//
// A stream word is 17 bits wide:
//   [16]   control-token flag (TOKEN_BIT)
//   [15:8] token opcode when the flag is set
//   [15:0] payload value when the flag is clear
//
// Contents:
//   glb_state_t          state encoding of the read-end sink FSM
//   GLB_WORD_W           stream word width
//   GLB_DONE_TOKEN       the stream-terminating token word
//   TOKEN_BIT            position of the control-token flag
//   OP_MSB / OP_LSB      bounds of the token opcode field
//   OP_STOP / OP_DONE    token opcodes
//   is_done_token()      classifies a word as the done token
// ----------------------------------------------------------------------------
package glb_stream_pkg;

    // Sink states: waiting for arm, armed (one settle cycle), receiving,
    // finished (sticky until the next flush).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RECV  = 2'd2,
        ST_FIN   = 2'd3
    } glb_state_t;

    localparam int          GLB_WORD_W     = 17;
    localparam logic [16:0] GLB_DONE_TOKEN = 17'h10100;

    localparam int TOKEN_BIT = 16;
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 8;

    localparam logic [7:0] OP_STOP = 8'h00;
    localparam logic [7:0] OP_DONE = 8'h01;

    // Only the flag and the opcode field identify the done token; the low
    // byte is ignored so any done-opcode token terminates the stream.
    function automatic logic is_done_token(input logic [GLB_WORD_W-1:0] word);
        return word[TOKEN_BIT] && (word[OP_MSB:OP_LSB] == OP_DONE);
    endfunction

endpackage : glb_stream_pkg

// File: rtl/glb_read_mem.sv
// ----------------------------------------------------------------------------
// glb_read_mem
//
// Capture buffer for glb_read: DEPTH x WIDTH array with one write port and
// one registered read port, both on the rising edge of clk. A read of an
// address being written at the same edge returns the previous contents.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write word
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], one edge after rd_addr is applied
// ----------------------------------------------------------------------------
module glb_read_mem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 17,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros/LUT RAM; only
    // the read register is reset, giving a defined rd_data after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments here and above make a same-edge read of
    // the written address return the old word (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : glb_read_mem

// File: rtl/glb_read.sv
// ----------------------------------------------------------------------------
// glb_read
//
// Read-end sink of a 17-bit ready/valid global-buffer stream. A flush pulse
// arms the sink; from the second cycle after flush falls it accepts words,
// stores every non-done word into a capture buffer at address num_rx and
// counts them. The stream ends on the done token, on reaching TX_SIZE stored
// words (TX_SIZE != 0), or on filling the buffer (which also sets overflow).
//
// Parameters:
//   TX_SIZE  expected payload words; 0 = unbounded
//   DEPTH    capture buffer entries, power of two, >= 2
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   flush     in   arm/restart, level-sampled
//   data      in   stream word (bit 16 token flag, [15:0] value)
//   valid     in   producer has a word on data
//   ready     out  sink accepts data this cycle
//   stall     in   backpressure, forces ready low
//   done      out  stream complete, sticky until flush/reset
//   overflow  out  buffer filled before the stream ended, sticky
//   num_rx    out  words stored since the last arm
//   rd_addr   in   readback address
//   rd_data   out  buffer word at rd_addr, registered
// ----------------------------------------------------------------------------
module glb_read
    import glb_stream_pkg::*;
#(
    parameter int unsigned TX_SIZE = 32,
    parameter int unsigned DEPTH   = 1024,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [GLB_WORD_W-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  stall,
    output logic                  done,
    output logic                  overflow,
    output logic [CW-1:0]         num_rx,
    input  logic [AW-1:0]         rd_addr,
    output logic [GLB_WORD_W-1:0] rd_data
);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    glb_state_t    state;
    logic [CW-1:0] num_rx_q;
    logic          done_q;
    logic          overflow_q;

    logic          xfer;
    logic          done_tok;
    logic          wr_en;
    logic [CW-1:0] num_rx_inc;
    logic          count_end;
    logic          fill_end;

    // ready depends only on registered state and stall, never on valid, so
    // a producer may wait for ready before raising valid without deadlock.
    assign ready = (state == ST_RECV) && !stall && (num_rx_q < DEPTH_CNT);

    assign xfer       = valid && ready;
    assign done_tok   = is_done_token(data);
    assign wr_en      = xfer && !done_tok;
    assign num_rx_inc = num_rx_q + 1'b1;

    // Both end conditions look at the count after the current stored word,
    // so the stream terminates at the accepting edge of the last word.
    assign count_end = (TX_SIZE != 0) && (32'(num_rx_inc) == TX_SIZE);
    assign fill_end  = (num_rx_inc == DEPTH_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            num_rx_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            // Re-arm from any state; buffer contents are intentionally kept.
            state      <= ST_ARMED;
            num_rx_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_ARMED: begin
                    state <= ST_RECV;
                end
                ST_RECV: begin
                    if (xfer) begin
                        if (done_tok) begin
                            state  <= ST_FIN;
                            done_q <= 1'b1;
                        end else begin
                            num_rx_q <= num_rx_inc;
                            // Count end is checked first so a transfer that
                            // both reaches TX_SIZE and fills the buffer is a
                            // clean finish, not an overflow.
                            if (count_end) begin
                                state  <= ST_FIN;
                                done_q <= 1'b1;
                            end else if (fill_end) begin
                                state      <= ST_FIN;
                                done_q     <= 1'b1;
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_FIN;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done     = done_q;
    assign overflow = overflow_q;
    assign num_rx   = num_rx_q;

    glb_read_mem #(
        .DEPTH (DEPTH),
        .WIDTH (GLB_WORD_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (num_rx_q[AW-1:0]),
        .wr_data (data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule : glb_read

// File: tb/tb_glb_read.sv
// ----------------------------------------------------------------------------
// tb_glb_read
//
// Directed bench for glb_read. Three instances share data/valid/stall/rd_addr
// and each has its own flush, so only the armed instance reacts:
//   u_a  TX_SIZE=32, DEPTH=1024
//   u_b  TX_SIZE=0,  DEPTH=8
//   u_c  TX_SIZE=4,  DEPTH=4   (count end and buffer full on the same word)
// Inputs change on the falling edge; outputs are sampled #1 after an edge.
// ----------------------------------------------------------------------------
module tb_glb_read;
    import glb_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flush;
    logic [16:0] data;
    logic        valid;
    logic        stall;
    logic [9:0]  rd_addr;

    logic [2:0]  ready;
    logic [2:0]  done;
    logic [2:0]  ovf;
    logic [10:0] num_a;
    logic [3:0]  num_b;
    logic [2:0]  num_c;
    logic [16:0] rd_a;
    logic [16:0] rd_b;
    logic [16:0] rd_c;

    int total = 0;
    int bad   = 0;
    bit stall_mode = 1'b0;

    always #5 clk = ~clk;

    glb_read #(.TX_SIZE(32), .DEPTH(1024)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]), .data(data), .valid(valid),
        .ready(ready[0]), .stall(stall), .done(done[0]), .overflow(ovf[0]),
        .num_rx(num_a), .rd_addr(rd_addr), .rd_data(rd_a)
    );

    glb_read #(.TX_SIZE(0), .DEPTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]), .data(data), .valid(valid),
        .ready(ready[1]), .stall(stall), .done(done[1]), .overflow(ovf[1]),
        .num_rx(num_b), .rd_addr(rd_addr[2:0]), .rd_data(rd_b)
    );

    glb_read #(.TX_SIZE(4), .DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]), .data(data), .valid(valid),
        .ready(ready[2]), .stall(stall), .done(done[2]), .overflow(ovf[2]),
        .num_rx(num_c), .rd_addr(rd_addr[1:0]), .rd_data(rd_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] num_of(input int s);
        case (s)
            0:       return 32'(num_a);
            1:       return 32'(num_b);
            default: return 32'(num_c);
        endcase
    endfunction

    function automatic logic [31:0] rd_of(input int s);
        case (s)
            0:       return 32'(rd_a);
            1:       return 32'(rd_b);
            default: return 32'(rd_c);
        endcase
    endfunction

    // Flush pulse for one cycle, then verify the ARMED cycle (ready low,
    // counters cleared) and the first RECV cycle (ready high).
    task automatic arm(input int s);
        @(negedge clk);
        valid    = 1'b0;
        flush[s] = 1'b1;
        @(negedge clk);
        flush[s] = 1'b0;
        #1;
        check("armed_ready", 32'(ready[s]), 32'd0);
        check("armed_num", num_of(s), 32'd0);
        check("armed_done", 32'(done[s]), 32'd0);
        check("armed_ovf", 32'(ovf[s]), 32'd0);
        @(negedge clk);
        #1;
        check("recv_ready", 32'(ready[s]), 32'd1);
    endtask

    // Offer one word until accepted; returns just after the accepting edge.
    task automatic send(input int s, input logic [16:0] w);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        if (stall_mode) stall = ~stall;
        data  = w;
        valid = 1'b1;
        for (int c = 0; c < 64 && !acc; c++) begin
            #1;
            if (stall_mode && stall) check("no_xfer_stall", 32'(ready[s]), 32'd0);
            if (ready[s]) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
                if (stall_mode) stall = ~stall;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL accept_timeout: word=%h not accepted by instance %0d", w, s);
        end
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
            if (stall_mode) stall = ~stall;
        end
    endtask

    task automatic readback(input int s, input int addr, input logic [16:0] exp, input string tag);
        @(negedge clk);
        valid   = 1'b0;
        rd_addr = 10'(addr);
        @(negedge clk);
        check(tag, rd_of(s), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        flush   = '0;
        data    = '0;
        valid   = 1'b0;
        stall   = 1'b0;
        rd_addr = '0;
        #23;
        rst_n = 1'b1;

        // ---- reset state, flush idle ----
        repeat (4) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_num_a", 32'(num_a), 32'd0);
        check("rst_num_b", 32'(num_b), 32'd0);
        check("rst_rd_a", 32'(rd_a), 32'd0);

        // ---- u_b: unbounded stream ended by the done token ----
        arm(1);
        send(1, 17'h0000A);
        send(1, 17'h0000B);
        send(1, 17'h10000);
        send(1, 17'h0000C);
        check("tok_num_before", num_of(1), 32'd4);
        check("tok_done_before", 32'(done[1]), 32'd0);
        send(1, GLB_DONE_TOKEN);
        check("tok_num", num_of(1), 32'd4);
        check("tok_done", 32'(done[1]), 32'd1);
        check("tok_ready", 32'(ready[1]), 32'd0);
        check("tok_ovf", 32'(ovf[1]), 32'd0);
        readback(1, 0, 17'h0000A, "tok_mem0");
        readback(1, 2, 17'h10000, "tok_mem2_stop");
        readback(1, 3, 17'h0000C, "tok_mem3");

        // ---- u_b: DEPTH=8 overflow ----
        arm(1);
        for (int i = 0; i < 8; i++) send(1, 17'(32'h100 + i));
        check("ovf_num", num_of(1), 32'd8);
        check("ovf_flag", 32'(ovf[1]), 32'd1);
        check("ovf_done", 32'(done[1]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data  = 17'(32'h108 + i);
            valid = 1'b1;
            #1;
            check("ovf_extra_ready", 32'(ready[1]), 32'd0);
        end
        @(negedge clk);
        valid = 1'b0;
        check("ovf_num_after", num_of(1), 32'd8);
        readback(1, 7, 17'h00107, "ovf_mem7");

        // ---- u_c: count end and full on the same word ----
        arm(2);
        for (int i = 0; i < 4; i++) send(2, 17'(32'h50 + i));
        check("tie_num", num_of(2), 32'd4);
        check("tie_done", 32'(done[2]), 32'd1);
        check("tie_ovf", 32'(ovf[2]), 32'd0);

        // ---- u_a: 32 back-to-back words, count end ----
        arm(0);
        for (int i = 0; i < 31; i++) send(0, 17'(i));
        check("b2b_num31", num_of(0), 32'd31);
        check("b2b_done_early", 32'(done[0]), 32'd0);
        send(0, 17'd31);
        check("b2b_num", num_of(0), 32'd32);
        check("b2b_done", 32'(done[0]), 32'd1);
        check("b2b_ready", 32'(ready[0]), 32'd0);
        check("b2b_ovf", 32'(ovf[0]), 32'd0);
        for (int i = 0; i < 32; i++) readback(0, i, 17'(i), "b2b_mem");

        // ---- u_a: stall toggling with random valid gaps ----
        arm(0);
        stall_mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            gap(int'($urandom_range(0, 2)));
            send(0, 17'(32'h200 + i));
        end
        stall_mode = 1'b0;
        @(negedge clk);
        stall = 1'b0;
        valid = 1'b0;
        check("stall_num", num_of(0), 32'd32);
        check("stall_done", 32'(done[0]), 32'd1);
        for (int i = 0; i < 32; i++) readback(0, i, 17'(32'h200 + i), "stall_mem");

        // ---- u_a: flush mid-stream, restart from address 0 ----
        arm(0);
        for (int i = 0; i < 5; i++) send(0, 17'(32'h300 + i));
        check("mid_num5", num_of(0), 32'd5);
        check("mid_done5", 32'(done[0]), 32'd0);
        arm(0);
        rd_addr = 10'd0;
        send(0, 17'h00400);
        check("rbw_old_data", rd_of(0), 32'h300);
        send(0, 17'h00401);
        check("rbw_new_data", rd_of(0), 32'h400);
        send(0, 17'h00402);
        check("mid_num3", num_of(0), 32'd3);
        check("mid_done3", 32'(done[0]), 32'd0);
        readback(0, 1, 17'h00401, "mid_mem1");
        readback(0, 2, 17'h00402, "mid_mem2");
        readback(0, 3, 17'h00303, "mid_mem3_kept");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_glb_read

// File: doc/glb_read.md
# glb_read

Stream sink that models the global-buffer read end of a 17-bit ready/valid fabric stream in the sparse memory-core test environment. After a flush pulse it accepts words from the array output, stores them in an internal buffer, counts transfers and raises `done` when the stream's done token arrives or the expected count is reached. The bench reads the captured words back through a side port for comparison against golden data.

## Interface
- `TX_SIZE`, 32: expected payload words. 0 means unbounded; only the done token or a full buffer ends the stream.
- `DEPTH`, 1024: capture buffer entries. Power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  arm/restart pulse, level-sampled.
- `data`  in  17  stream word; bit 16 = control-token flag, [15:0] = value.
- `valid`  in  1  producer has a word on `data`.
- `ready`  out  1  sink accepts `data` this cycle.
- `stall`  in  1  bench backpressure; forces `ready` low.
- `done`  out  1  stream complete; sticky until flush or reset.
- `overflow`  out  1  buffer filled before the stream ended; sticky.
- `num_rx`  out  $clog2(DEPTH)+1  words stored since the last arm.
- `rd_addr`  in  $clog2(DEPTH)  bench readback address.
- `rd_data`  out  17  buffer word at `rd_addr`, registered.

## Operation
- States: IDLE, ARMED, RECV, FIN.
- IDLE → ARMED when `flush`=1. ARMED → RECV on the first cycle `flush`=0. RECV → FIN on end of stream. FIN holds.
- `flush`=1 in any state → ARMED. On entry to ARMED: `num_rx`, `done` and `overflow` clear. Buffer contents are kept.
- `ready` = (state==RECV) && !`stall` && (`num_rx` < DEPTH). It is combinational from registered state and has no path from `valid`.
- Transfer = `valid` && `ready` at a rising edge.
- Done token is 17'h10100, defined as `data[16]`=1 and `data[15:8]`=8'h01. On transfer it is not stored and does not increment `num_rx`; the state goes to FIN.
- Any other word, including stop tokens with `data[16]`=1 and `data[15:8]`=0, is written to `mem[num_rx]` and `num_rx` increments.
- Count end: when a stored transfer makes `num_rx` == TX_SIZE and TX_SIZE≠0, state goes to FIN.
- Buffer full: when `num_rx` reaches DEPTH in RECV without a done token or count end, state goes to FIN and `overflow` is set.
- `done` = (state==FIN).

## Timing
- Reset values: state IDLE; `ready`=0, `done`=0, `overflow`=0, `num_rx`=0, `rd_data`=0. Buffer contents are undefined.
- Write latency is 0: the word is in the buffer at the accepting edge.
- `done` rises in the cycle after the terminating transfer. `ready` is 0 from that same cycle.
- Readback latency is 1: `rd_data` shows `mem[rd_addr]` one edge after `rd_addr` is applied.
- Readback of an address written at the same edge returns the old data (read-before-write).
- Earliest acceptance is the second cycle after `flush` falls: one cycle in ARMED, then RECV.
- Tie-break when a count-end transfer fills the last entry at the same time: count end wins and `overflow` stays 0.
- `valid` may drop without a transfer. No stability requirement is placed on the producer.

## Structure
- Package `glb_stream_pkg` holds:
  - the state enum;
  - `GLB_DONE_TOKEN` = 17'h10100;
  - `TOKEN_BIT` = 16;
  - the token opcode field [15:8] and its opcodes (`OP_STOP`=8'h00, `OP_DONE`=8'h01).
- Sub-module `glb_read_mem`: 1-write/1-read, DEPTH×17 array with registered read port. It is instantiated once.
- The FSM, counter and handshake live in the top module.

## Test plan
- Reset with `flush` idle → `ready`=0, `done`=0, `num_rx`=0 indefinitely.
- Flush pulse, then 32 back-to-back words 0x0000..0x001F (TX_SIZE=32) → `num_rx`=32; `done`=1 one cycle after the last word; readback of addresses 0..31 returns 0x0000..0x001F.
- TX_SIZE=0: words 0xA,0xB, stop token 0x10000, 0xC, then 0x10100 → `num_rx`=4; mem[2]=0x10000; done token not stored; `done`=1.
- `stall` toggled every other cycle with random `valid` gaps, 32 words → every word stored exactly once and in order; no transfer occurs while `stall`=1.
- DEPTH=8, TX_SIZE=0, 10 words offered → 8 accepted, `overflow`=1, `done`=1, `ready`=0 for words 9–10.
- Flush asserted mid-stream after 5 words → `num_rx`=0, `done`=0; the new stream writes from address 0 after `flush` falls.
